axi_lite_to_apb_sn: RTL and testbench
=====================================

Name: axi_lite_to_apb_sn

Overview:
Parametrised AXI-Lite slave to APB3/APB4 master bridge for NUM_PSLAVE peripherals. It generalises the fixed four-slave AXI-to-APB path to any slave count with a packed address map. It adds PREADY wait states, PSLVERR/DECERR mapping, an access timeout and fair read/write arbitration. It sits between the AXI BFM/interconnect and the APB peripheral memories.

Parameters:
NUM_PSLAVE, 4, number of APB slaves (1..16)
WIDTH_PAD, 32, APB/AXI address width
WIDTH_PDA, 32, data width (32 or 64)
WIDTH_PDS, WIDTH_PDA/8, strobe width
AXI_WIDTH_SID, 8, AXI ID width (channel id + id), echoed unchanged
ADDR_PBASE, {32'h0003_0000,32'h0002_0000,32'h0001_0000,32'h0000_0000}, packed NUM_PSLAVE*WIDTH_PAD bases, slave i at [i*WIDTH_PAD +: WIDTH_PAD]
ADDR_PLENGTH, {8'd16,8'd16,8'd16,8'd16}, packed NUM_PSLAVE*8, log2 of region size per slave
TIMEOUT, 256, max ACCESS cycles before abort; 0 disables

Ports:
PCLK  in  1  single clock for AXI and APB sides
PRESET  in  1  synchronous reset, active-high
AWID/AWADDR/AWPROT/AWVALID  in  SID/PAD/3/1  write address
AWREADY  out  1
WDATA/WSTRB/WVALID  in  PDA/PDS/1  write data
WREADY  out  1
BID/BRESP/BVALID  out  SID/2/1  write response
BREADY  in  1
ARID/ARADDR/ARPROT/ARVALID  in  SID/PAD/3/1  read address
ARREADY  out  1
RID/RDATA/RRESP/RVALID  out  SID/PDA/2/1  read response; RLAST not present (single beat)
RREADY  in  1
S_PADDR  out  PAD  APB address
S_PWRITE/S_PENABLE  out  1 each
S_PWDATA  out  PDA
S_PSTRB  out  PDS  WSTRB on writes, 0 on reads
S_PPROT  out  3
S_PSEL  out  NUM_PSLAVE  one-hot select
S_PRDATA  in  NUM_PSLAVE*PDA  packed read data
S_PREADY  in  NUM_PSLAVE
S_PSLVERR  in  NUM_PSLAVE

Behaviour:
- Reset (PRESET=1 at a PCLK edge): all outputs 0, state IDLE, priority=read-first, timeout counter 0. Reset mid-transfer aborts immediately and produces no response.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE, write candidate: AWVALID&&WVALID both high. Read candidate: ARVALID.
  - Only one candidate: grant it.
  - Both: grant the type not granted last, then flip priority.
  - Grant cycle: pulse AWREADY+WREADY together, or ARREADY, for exactly one cycle.
  - Latch ID, address, prot, data and strobe on grant.
- Decode: slave i hits when addr>>PLENGTH_i == PBASE_i>>PLENGTH_i; lowest index wins on overlap.
  - Miss: go to RESP with DECERR (2'b11), RDATA=0, no PSEL asserted.
  - Hit: go to SETUP.
- SETUP (1 cycle): S_PSEL[i]=1, S_PENABLE=0, S_PADDR/S_PWRITE/S_PWDATA/S_PSTRB/S_PPROT valid. Go to ACCESS.
- ACCESS: S_PENABLE=1, all APB outputs stable.
  - On S_PREADY[i]=1: capture S_PRDATA slice i, resp = S_PSLVERR[i] ? 2'b10 : 2'b00. Drop PSEL/PENABLE next cycle; go to RESP.
  - Counter counts ACCESS cycles without PREADY. At TIMEOUT (≠0) abort: drop PSEL/PENABLE, resp SLVERR, RDATA=0.
- RESP: BVALID or RVALID held with stable ID/resp/data until BREADY/RREADY. Handshake cycle returns to IDLE; the next grant is possible the following cycle.
- Minimum latency with PREADY tied high: grant T0, SETUP T1, ACCESS T2, VALID T3. Throughput is 1 transaction per 4 cycles when the master accepts immediately.
- AXI ready signals are never asserted outside IDLE. Inputs that drop before grant are not latched.
- S_PWDATA/S_PSTRB are 0 during reads. S_PADDR is held after the access (no toggle).

Test Plan:
- Write 0x0001_0004 data 0xDEADBEEF, WSTRB 0xF, PREADY=1 -> S_PSEL=4'b0010 in SETUP, PENABLE one cycle later, BRESP=00 at cycle 3, BID echoes AWID=0x15.
- Read 0x0002_0008, slave 2 PREADY low 3 cycles, PRDATA=0x12345678 -> ACCESS lasts 4 cycles, RDATA=0x12345678, RRESP=00.
- Read 0x0009_0000 (unmapped) -> no PSEL ever asserted, RRESP=11, RDATA=0, RVALID 1 cycle after ARREADY.
- TIMEOUT=8, slave 0 PREADY stuck low -> PSEL drops after 8 ACCESS cycles, BRESP=10; a following read to slave 1 completes normally.
- AW/W and AR valid simultaneously for two rounds -> grant order read, write, read, write; BRESP and RRESP each delivered once.
- Assert PRESET during ACCESS with BREADY=0 -> next cycle all outputs 0, no BVALID issued; a fresh write afterwards completes with BRESP=00.

Source files
------------

// File: rtl/axi_lite_to_apb_sn_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_to_apb_sn_if
//  Purpose  : Bundles the AXI-Lite slave channels and the multi-slave APB
//             master signals of the axi_lite_to_apb_sn bridge.
//  Modports : slave  - the bridge view (AXI-Lite slave, APB master)
//             master - the environment view (AXI-Lite master, APB slaves)
//  Signals  : AW/W/B and AR/R channels (single-beat, no RLAST),
//             S_PADDR/S_PWRITE/S_PENABLE/S_PWDATA/S_PSTRB/S_PPROT/S_PSEL out,
//             S_PRDATA/S_PREADY/S_PSLVERR packed per slave in.
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_to_apb_sn_if #(
    parameter int NUM_PSLAVE    = 4,
    parameter int WIDTH_PAD     = 32,
    parameter int WIDTH_PDA     = 32,
    parameter int WIDTH_PDS     = WIDTH_PDA / 8,
    parameter int AXI_WIDTH_SID = 8
);
    // AXI-Lite write address / data / response
    logic [AXI_WIDTH_SID-1:0]        AWID;
    logic [WIDTH_PAD-1:0]            AWADDR;
    logic [2:0]                      AWPROT;
    logic                            AWVALID;
    logic                            AWREADY;
    logic [WIDTH_PDA-1:0]            WDATA;
    logic [WIDTH_PDS-1:0]            WSTRB;
    logic                            WVALID;
    logic                            WREADY;
    logic [AXI_WIDTH_SID-1:0]        BID;
    logic [1:0]                      BRESP;
    logic                            BVALID;
    logic                            BREADY;
    // AXI-Lite read address / data
    logic [AXI_WIDTH_SID-1:0]        ARID;
    logic [WIDTH_PAD-1:0]            ARADDR;
    logic [2:0]                      ARPROT;
    logic                            ARVALID;
    logic                            ARREADY;
    logic [AXI_WIDTH_SID-1:0]        RID;
    logic [WIDTH_PDA-1:0]            RDATA;
    logic [1:0]                      RRESP;
    logic                            RVALID;
    logic                            RREADY;
    // APB master side
    logic [WIDTH_PAD-1:0]            S_PADDR;
    logic                            S_PWRITE;
    logic                            S_PENABLE;
    logic [WIDTH_PDA-1:0]            S_PWDATA;
    logic [WIDTH_PDS-1:0]            S_PSTRB;
    logic [2:0]                      S_PPROT;
    logic [NUM_PSLAVE-1:0]           S_PSEL;
    logic [NUM_PSLAVE*WIDTH_PDA-1:0] S_PRDATA;
    logic [NUM_PSLAVE-1:0]           S_PREADY;
    logic [NUM_PSLAVE-1:0]           S_PSLVERR;

    modport slave (
        input  AWID, AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARID, ARADDR, ARPROT, ARVALID, RREADY,
        input  S_PRDATA, S_PREADY, S_PSLVERR,
        output AWREADY, WREADY, BID, BRESP, BVALID,
        output ARREADY, RID, RDATA, RRESP, RVALID,
        output S_PADDR, S_PWRITE, S_PENABLE, S_PWDATA, S_PSTRB, S_PPROT, S_PSEL
    );

    modport master (
        output AWID, AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARID, ARADDR, ARPROT, ARVALID, RREADY,
        output S_PRDATA, S_PREADY, S_PSLVERR,
        input  AWREADY, WREADY, BID, BRESP, BVALID,
        input  ARREADY, RID, RDATA, RRESP, RVALID,
        input  S_PADDR, S_PWRITE, S_PENABLE, S_PWDATA, S_PSTRB, S_PPROT, S_PSEL
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_to_apb_sn.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_to_apb_sn
//  Purpose  : AXI-Lite slave to APB3/APB4 master bridge for NUM_PSLAVE
//             peripherals with a packed base/size address map, PREADY wait
//             states, PSLVERR/DECERR response mapping, an ACCESS timeout and
//             alternating read/write arbitration. One transaction in flight.
//  Ports    : PCLK   - single clock for both sides
//             PRESET - synchronous active-high reset
//             bus    - axi_lite_to_apb_sn_if.slave (AXI-Lite + APB signals)
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_to_apb_sn #(
    parameter int NUM_PSLAVE    = 4,
    parameter int WIDTH_PAD     = 32,
    parameter int WIDTH_PDA     = 32,
    parameter int WIDTH_PDS     = WIDTH_PDA / 8,
    parameter int AXI_WIDTH_SID = 8,
    parameter logic [NUM_PSLAVE*WIDTH_PAD-1:0] ADDR_PBASE =
        {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_PSLAVE*8-1:0] ADDR_PLENGTH =
        {8'd16, 8'd16, 8'd16, 8'd16},
    parameter int TIMEOUT       = 256
) (
    input wire                  PCLK,
    input wire                  PRESET,
    axi_lite_to_apb_sn_if.slave bus
);

    localparam int c_IDX_W = (NUM_PSLAVE > 1) ? $clog2(NUM_PSLAVE) : 1;
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                   r_state;
    logic                     r_last_wr;   // type of the most recent grant
    logic                     r_wr;
    logic [AXI_WIDTH_SID-1:0] r_id;
    logic [c_IDX_W-1:0]       r_idx;
    logic [c_CNT_W-1:0]       r_cnt;

    logic [NUM_PSLAVE-1:0]    r_psel;
    logic                     r_penable;
    logic [WIDTH_PAD-1:0]     r_paddr;
    logic                     r_pwrite;
    logic [WIDTH_PDA-1:0]     r_pwdata;
    logic [WIDTH_PDS-1:0]     r_pstrb;
    logic [2:0]               r_pprot;

    logic                     r_bvalid;
    logic [AXI_WIDTH_SID-1:0] r_bid;
    logic [1:0]               r_bresp;
    logic                     r_rvalid;
    logic [AXI_WIDTH_SID-1:0] r_rid;
    logic [1:0]               r_rresp;
    logic [WIDTH_PDA-1:0]     r_rdata;

    logic                     w_idle;
    logic                     w_wr_cand;
    logic                     w_rd_cand;
    logic                     w_grant_wr;
    logic                     w_grant_rd;
    logic [WIDTH_PAD-1:0]     w_addr;
    logic                     w_hit;
    logic [c_IDX_W-1:0]       w_sel_idx;
    logic                     w_pready;
    logic                     w_pslverr;
    logic [WIDTH_PDA-1:0]     w_prdata;
    logic                     w_timeout;
    logic                     w_resp_done;

    // ------------------------------------------------------------------
    // Arbitration. Ready is combinational on valid so that the grant cycle
    // is also the AXI handshake cycle; on contention the type that was not
    // granted last wins. r_last_wr resets high so reads go first.
    // ------------------------------------------------------------------
    assign w_idle     = (r_state == S_IDLE) && !PRESET;
    assign w_wr_cand  = bus.AWVALID && bus.WVALID;
    assign w_rd_cand  = bus.ARVALID;
    assign w_grant_wr = w_idle && w_wr_cand && (!w_rd_cand || !r_last_wr);
    assign w_grant_rd = w_idle && w_rd_cand && !w_grant_wr;
    assign w_addr     = w_grant_wr ? bus.AWADDR : bus.ARADDR;

    // Address decode; scanning downward makes the lowest index win.
    always_comb begin
        w_hit     = 1'b0;
        w_sel_idx = '0;
        for (int i = NUM_PSLAVE - 1; i >= 0; i--) begin
            if ((w_addr >> ADDR_PLENGTH[i*8 +: 8]) ==
                (ADDR_PBASE[i*WIDTH_PAD +: WIDTH_PAD] >> ADDR_PLENGTH[i*8 +: 8])) begin
                w_hit     = 1'b1;
                w_sel_idx = c_IDX_W'(i);
            end
        end
    end

    // Response side of the selected slave.
    assign w_pready  = bus.S_PREADY[r_idx];
    assign w_pslverr = bus.S_PSLVERR[r_idx];
    assign w_prdata  = bus.S_PRDATA[r_idx*WIDTH_PDA +: WIDTH_PDA];

    // r_cnt holds the number of ACCESS cycles already spent without PREADY,
    // so the abort happens in the TIMEOUT-th ACCESS cycle.
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == c_CNT_W'(TIMEOUT - 1));
    assign w_resp_done = (r_bvalid && bus.BREADY) || (r_rvalid && bus.RREADY);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_last_wr <= 1'b1;
            r_wr      <= 1'b0;
            r_id      <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pprot   <= '0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= '0;
            r_rvalid  <= 1'b0;
            r_rid     <= '0;
            r_rresp   <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_wr || w_grant_rd) begin
                        r_last_wr <= w_grant_wr;
                        r_wr      <= w_grant_wr;
                        r_id      <= w_grant_wr ? bus.AWID : bus.ARID;
                        if (w_hit) begin
                            r_idx    <= w_sel_idx;
                            r_psel   <= NUM_PSLAVE'(1) << w_sel_idx;
                            r_paddr  <= w_addr;
                            r_pwrite <= w_grant_wr;
                            r_pwdata <= w_grant_wr ? bus.WDATA : '0;
                            r_pstrb  <= w_grant_wr ? bus.WSTRB : '0;
                            r_pprot  <= w_grant_wr ? bus.AWPROT : bus.ARPROT;
                            r_state  <= S_SETUP;
                        end else begin
                            // Unmapped: answer directly, APB stays untouched.
                            if (w_grant_wr) begin
                                r_bvalid <= 1'b1;
                                r_bid    <= bus.AWID;
                                r_bresp  <= c_RESP_DECERR;
                            end else begin
                                r_rvalid <= 1'b1;
                                r_rid    <= bus.ARID;
                                r_rresp  <= c_RESP_DECERR;
                                r_rdata  <= '0;
                            end
                            r_state <= S_RESP;
                        end
                    end
                end

                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (w_pready || w_timeout) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_state   <= S_RESP;
                        if (r_wr) begin
                            r_bvalid <= 1'b1;
                            r_bid    <= r_id;
                            r_bresp  <= (!w_pready || w_pslverr) ? c_RESP_SLVERR : c_RESP_OKAY;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rid    <= r_id;
                            r_rresp  <= (!w_pready || w_pslverr) ? c_RESP_SLVERR : c_RESP_OKAY;
                            r_rdata  <= w_pready ? w_prdata : '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (w_resp_done) begin
                        r_bvalid <= 1'b0;
                        r_rvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.AWREADY   = w_grant_wr;
    assign bus.WREADY    = w_grant_wr;
    assign bus.ARREADY   = w_grant_rd;
    assign bus.BVALID    = r_bvalid;
    assign bus.BID       = r_bid;
    assign bus.BRESP     = r_bresp;
    assign bus.RVALID    = r_rvalid;
    assign bus.RID       = r_rid;
    assign bus.RRESP     = r_rresp;
    assign bus.RDATA     = r_rdata;
    assign bus.S_PSEL    = r_psel;
    assign bus.S_PENABLE = r_penable;
    assign bus.S_PADDR   = r_paddr;
    assign bus.S_PWRITE  = r_pwrite;
    assign bus.S_PWDATA  = r_pwdata;
    assign bus.S_PSTRB   = r_pstrb;
    assign bus.S_PPROT   = r_pprot;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_to_apb_sn.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_to_apb_sn
//  Purpose  : Self-checking bench for axi_lite_to_apb_sn (TIMEOUT = 8).
//             Table of directed transactions plus hand-written sequences for
//             arbitration and reset in the middle of an access.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_to_apb_sn;

    logic PCLK;
    logic PRESET;

    axi_lite_to_apb_sn_if #(
        .NUM_PSLAVE(4), .WIDTH_PAD(32), .WIDTH_PDA(32), .AXI_WIDTH_SID(8)
    ) bus ();

    axi_lite_to_apb_sn #(
        .NUM_PSLAVE(4), .WIDTH_PAD(32), .WIDTH_PDA(32), .AXI_WIDTH_SID(8),
        .TIMEOUT(8)
    ) u_dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [7:0]  id;
        logic [2:0]  prot;
        bit          miss;
        int          sidx;
        int          delay;     // ACCESS cycles with PREADY low
        bit          slverr;
        logic [31:0] prdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_acc;   // expected ACCESS cycles
        int          hold;      // cycles BREADY/RREADY held low
    } vec_t;

    localparam int c_NVEC = 9;
    vec_t vecs [c_NVEC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic logic [127:0] outs_axi();
        return {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.BID, bus.BRESP,
                bus.RVALID, bus.RID, bus.RRESP, bus.RDATA};
    endfunction

    function automatic logic [127:0] outs_apb();
        return {bus.S_PADDR, bus.S_PWRITE, bus.S_PENABLE, bus.S_PWDATA, bus.S_PSTRB,
                bus.S_PPROT, bus.S_PSEL};
    endfunction

    task automatic drop_valids();
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        bus.ARVALID = 1'b0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        logic [3:0] exp_psel;
        logic [3:0] sel_seen;
        int         acc;
        int         setup;
        int         lat;
        bit         granted;
        bit         stable_bad;
        exp_psel = v.miss ? 4'd0 : (4'd1 << v.sidx);
        sel_seen = '0;
        acc = 0; setup = 0; lat = 0; granted = 0; stable_bad = 0;

        // Non-selected slaves answer "ready with error" so mis-steering shows.
        bus.S_PREADY  = 4'hF;
        bus.S_PSLVERR = 4'hF;
        for (int i = 0; i < 4; i++) bus.S_PRDATA[i*32 +: 32] = 32'hA5A5_0000 | i;
        if (!v.miss) begin
            bus.S_PREADY[v.sidx]           = 1'b0;
            bus.S_PSLVERR[v.sidx]          = v.slverr;
            bus.S_PRDATA[v.sidx*32 +: 32]  = v.prdata;
        end

        bus.BREADY = (v.hold == 0);
        bus.RREADY = (v.hold == 0);
        if (v.wr) begin
            bus.AWID = v.id; bus.AWADDR = v.addr; bus.AWPROT = v.prot;
            bus.WDATA = v.wdata; bus.WSTRB = v.strb;
            bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        end else begin
            bus.ARID = v.id; bus.ARADDR = v.addr; bus.ARPROT = v.prot;
            bus.ARVALID = 1'b1;
        end
        #1;
        for (int c = 0; c < 20; c++) begin
            if (v.wr ? (bus.AWREADY && bus.WREADY) : bus.ARREADY) begin
                granted = 1'b1;
                break;
            end
            tick();
        end
        chk($sformatf("v%0d_grant", k), granted, 1'b1);
        tick();
        drop_valids();

        for (int n = 1; n <= 40; n++) begin
            sel_seen |= bus.S_PSEL;
            if (bus.S_PSEL != 4'd0 && !bus.S_PENABLE) begin
                setup++;
                if (setup == 1)
                    chk($sformatf("v%0d_setup_bus", k),
                        {bus.S_PADDR, bus.S_PWRITE, bus.S_PWDATA, bus.S_PSTRB, bus.S_PPROT},
                        {v.addr, v.wr, (v.wr ? v.wdata : 32'h0), (v.wr ? v.strb : 4'h0), v.prot});
            end
            if (bus.S_PENABLE) begin
                acc++;
                if (!v.miss) bus.S_PREADY[v.sidx] = (acc > v.delay);
            end
            if (v.wr ? bus.BVALID : bus.RVALID) begin
                lat = n;
                break;
            end
            tick();
        end

        chk($sformatf("v%0d_latency", k), lat, v.miss ? 1 : v.exp_acc + 2);
        chk($sformatf("v%0d_setup_cycles", k), setup, v.miss ? 0 : 1);
        chk($sformatf("v%0d_access_cycles", k), acc, v.exp_acc);
        chk($sformatf("v%0d_psel", k), sel_seen, exp_psel);
        if (v.wr) begin
            chk($sformatf("v%0d_bresp", k), bus.BRESP, v.exp_resp);
            chk($sformatf("v%0d_bid", k), bus.BID, v.id);
        end else begin
            chk($sformatf("v%0d_rresp", k), bus.RRESP, v.exp_resp);
            chk($sformatf("v%0d_rid", k), bus.RID, v.id);
            chk($sformatf("v%0d_rdata", k), bus.RDATA, v.exp_rdata);
        end

        for (int h = 0; h < v.hold; h++) begin
            tick();
            if (v.wr)
                stable_bad |= !(bus.BVALID && bus.BID == v.id && bus.BRESP == v.exp_resp);
            else
                stable_bad |= !(bus.RVALID && bus.RID == v.id && bus.RRESP == v.exp_resp &&
                                bus.RDATA == v.exp_rdata);
        end
        chk($sformatf("v%0d_hold_stable", k), stable_bad, 1'b0);
        bus.BREADY = 1'b1;
        bus.RREADY = 1'b1;
        tick();
        chk($sformatf("v%0d_valid_drop", k), {bus.BVALID, bus.RVALID}, 2'b00);
        chk($sformatf("v%0d_apb_idle", k), {bus.S_PSEL, bus.S_PENABLE}, 5'd0);
        if (!v.miss) chk($sformatf("v%0d_paddr_held", k), bus.S_PADDR, v.addr);
        bus.BREADY = 1'b0;
        bus.RREADY = 1'b0;
    endtask

    // Both request types pending for two rounds: expect R, W, R, W.
    task automatic arbitration();
        logic [3:0] order;
        int         ngrant;
        int         nb;
        int         nr;
        int         bad;
        bit         gw;
        bit         gr;
        order = '0; ngrant = 0; nb = 0; nr = 0; bad = 0;
        bus.S_PREADY = 4'hF; bus.S_PSLVERR = 4'h0;
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        for (int r = 0; r < 2; r++) begin
            bus.AWID = 8'h60 + 8'(r); bus.AWADDR = 32'h0001_0000; bus.AWPROT = 3'd0;
            bus.WDATA = 32'h0F0F_0000 + 32'(r); bus.WSTRB = 4'hF;
            bus.ARID = 8'h70 + 8'(r); bus.ARADDR = 32'h0002_0000; bus.ARPROT = 3'd0;
            bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
            #1;
            for (int c = 0; c < 40 && (bus.AWVALID || bus.ARVALID); c++) begin
                gw = bus.AWREADY && bus.WREADY;
                gr = bus.ARREADY;
                if ((bus.AWREADY && bus.ARREADY) || (bus.AWREADY != bus.WREADY)) bad++;
                if (gr) begin
                    if (ngrant < 4) order[3-ngrant] = 1'b0;
                    ngrant++;
                end
                if (gw) begin
                    if (ngrant < 4) order[3-ngrant] = 1'b1;
                    ngrant++;
                end
                if (bus.BVALID) nb++;
                if (bus.RVALID) nr++;
                tick();
                if (gw) begin bus.AWVALID = 1'b0; bus.WVALID = 1'b0; end
                if (gr) bus.ARVALID = 1'b0;
            end
            for (int c = 0; c < 10; c++) begin
                if (bus.AWREADY || bus.ARREADY) bad++;
                if (bus.BVALID) nb++;
                if (bus.RVALID) nr++;
                tick();
            end
        end
        chk("arb_grant_count", ngrant, 4);
        chk("arb_order_rwrw", order, 4'b0101);
        chk("arb_bresp_count", nb, 2);
        chk("arb_rresp_count", nr, 2);
        chk("arb_ready_exclusive", bad, 0);
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    endtask

    // Reset while a write sits in ACCESS with BREADY low.
    task automatic reset_mid_access();
        bit granted;
        bit bad;
        granted = 1'b0; bad = 1'b0;
        bus.S_PREADY = 4'h0; bus.S_PSLVERR = 4'h0;
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        bus.AWID = 8'h5A; bus.AWADDR = 32'h0000_0040; bus.AWPROT = 3'd1;
        bus.WDATA = 32'h1357_9BDF; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (bus.AWREADY) begin granted = 1'b1; break; end
            tick();
        end
        chk("rst_mid_grant", granted, 1'b1);
        tick();
        drop_valids();
        for (int c = 0; c < 10 && !bus.S_PENABLE; c++) tick();
        chk("rst_mid_in_access", bus.S_PENABLE, 1'b1);
        tick();
        PRESET = 1'b1;
        tick();
        chk("rst_mid_axi_zero", outs_axi(), '0);
        chk("rst_mid_apb_zero", outs_apb(), '0);
        PRESET = 1'b0;
        bus.S_PREADY = 4'hF;
        bus.BREADY = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            bad |= bus.BVALID || (bus.S_PSEL != 4'd0);
        end
        chk("rst_mid_no_response", bad, 1'b0);
        bus.BREADY = 1'b0;
    endtask

    initial begin
        //          wr  addr          wdata         strb  id     prot  miss sidx dly err prdata        resp   rdata         acc hold
        vecs[0] = '{1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 8'h15, 3'd0, 1'b0, 1, 0,  1'b0, 32'h0,        2'b00, 32'h0,        1, 0};
        vecs[1] = '{1'b0, 32'h0002_0008, 32'h0,        4'h0, 8'h2A, 3'd2, 1'b0, 2, 3,  1'b0, 32'h1234_5678, 2'b00, 32'h1234_5678, 4, 2};
        vecs[2] = '{1'b0, 32'h0009_0000, 32'h0,        4'h0, 8'h33, 3'd0, 1'b1, 0, 0,  1'b0, 32'h0,        2'b11, 32'h0,        0, 0};
        vecs[3] = '{1'b1, 32'h0003_00FC, 32'hCAFE_F00D, 4'h3, 8'h81, 3'd5, 1'b0, 3, 1,  1'b1, 32'h0,        2'b10, 32'h0,        2, 3};
        vecs[4] = '{1'b1, 32'h0000_0010, 32'h1111_2222, 4'hF, 8'h07, 3'd0, 1'b0, 0, 99, 1'b0, 32'h0,        2'b10, 32'h0,        8, 0};
        vecs[5] = '{1'b0, 32'h0001_0020, 32'h0,        4'h0, 8'h44, 3'd0, 1'b0, 1, 0,  1'b0, 32'hFEED_FACE, 2'b00, 32'hFEED_FACE, 1, 0};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 8'h99, 3'd4, 1'b0, 0, 2,  1'b1, 32'h0BAD_C0DE, 2'b10, 32'h0BAD_C0DE, 3, 0};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'h5555_AAAA, 4'hF, 8'hFE, 3'd0, 1'b1, 0, 0,  1'b0, 32'h0,        2'b11, 32'h0,        0, 1};
        vecs[8] = '{1'b0, 32'h0003_FFFC, 32'h0,        4'h0, 8'hC3, 3'd0, 1'b0, 3, 7,  1'b0, 32'h7654_3210, 2'b00, 32'h7654_3210, 8, 0};

        PRESET = 1'b1;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        bus.S_PRDATA = '0; bus.S_PREADY = '0; bus.S_PSLVERR = '0;
        repeat (3) tick();
        chk("reset_axi_zero", outs_axi(), '0);
        chk("reset_apb_zero", outs_apb(), '0);
        PRESET = 1'b0;
        tick();
        chk("post_reset_axi_zero", outs_axi(), '0);

        arbitration();
        for (int k = 0; k < c_NVEC; k++) run_vec(k, vecs[k]);
        reset_mid_access();
        run_vec(100, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
